// File: rtl/connect_n_pkg.sv
// connect_n_pkg: cell codes, FSM states, scan directions and their (dr,dc) offsets
package connect_n_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, PL_A = 2'b01, PL_B = 2'b10} cell_t;
  typedef enum logic [2:0] {S_IDLE, S_DROP, S_CHECK, S_HILITE, S_FINISH} state_t;
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_t;
  localparam logic signed [1:0] DIR_DR [4] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1};
  localparam logic signed [1:0] DIR_DC [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};
endpackage

// File: rtl/connect_n_core_cursor.sv
// column_cursor: one-hot rotating column cursor
//   clk, rst : clock, sync active-high clear (cursor back to column 0)
//   left     : rotate toward column 0, wrapping to COLS-1
//   right    : rotate toward COLS-1, wrapping to column 0; both together hold
//   cursor   : one-hot active column
module column_cursor #(
  parameter int COLS = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            left,
  input  logic            right,
  output logic [COLS-1:0] cursor
);
  logic [COLS-1:0] cursor_q, cursor_d;
  always_comb
    cursor_d = (left && !right) ? {cursor_q[0], cursor_q[COLS-1:1]} :
               (right && !left) ? {cursor_q[COLS-2:0], cursor_q[COLS-1]} : cursor_q;
  always_ff @(posedge clk)
    cursor_q <= rst ? COLS'(1) : cursor_d;
  assign cursor = cursor_q;
endmodule

// File: rtl/connect_n_core.sv
// connect_n_core: connect-N gravity board with cursor, drop, turn and one-probe-per-cycle win/draw scan
//   clk, rst, new_game     : clock, sync clears (rst and new_game act the same)
//   left, right            : cursor pulses; put_valid/put_ready drop handshake
//   cursor, player, board  : one-hot column, side to move, 2 bits per cell (r*COLS+c)
//   win_mask               : cells of the winning run
//   move_done, invalid_move: 1-cycle pulses; win_a, win_b, full_panel: sticky results
module connect_n_core
  import connect_n_pkg::*;
#(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic                   left,
  input  logic                   right,
  input  logic                   put_valid,
  output logic                   put_ready,
  output logic [COLS-1:0]        cursor,
  output logic                   player,
  output logic [ROWS*COLS*2-1:0] board,
  output logic [ROWS*COLS-1:0]   win_mask,
  output logic                   move_done,
  output logic                   invalid_move,
  output logic                   win_a,
  output logic                   win_b,
  output logic                   full_panel
);
  localparam int N   = ROWS * COLS;
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int PRW = RW + 1;
  localparam int PCW = CW + 1;
  localparam int HW  = $clog2(ROWS + 1);
  localparam int KW  = $clog2(WIN_LEN + 1);
  localparam int IW  = $clog2(2 * N);
  localparam int MW  = $clog2(N);
  function automatic logic [IW-1:0] bidx(int r, int c);
    return IW'((r * COLS + c) * 2);
  endfunction
  function automatic logic [MW-1:0] midx(int r, int c);
    return MW'(r * COLS + c);
  endfunction
  state_t              state_q, state_d;
  dir_t                dir_q, dir_d;
  logic [2*N-1:0]      board_q, board_d;
  logic [N-1:0]        mask_q, mask_d;
  logic [HW-1:0]       h_q [COLS];
  logic [HW-1:0]       h_d [COLS];
  logic                player_q, player_d, win_a_q, win_a_d, win_b_q, win_b_d;
  logic                full_q, full_d, inv_q, inv_d, side_q, side_d;
  logic [CW-1:0]       col_q, col_d, cur_col;
  logic [KW-1:0]       cnt_q, cnt_d;
  logic signed [RW:0]  lr_q, lr_d, pr_q, pr_d, ner_q, ner_d, dr_s;
  logic signed [CW:0]  lc_q, lc_d, pc_q, pc_d, nec_q, nec_d, dc_s;
  cell_t               me;
  logic [1:0]          pcell;
  logic                in_b, match, all_full;
  column_cursor #(.COLS(COLS)) u_cursor (
    .clk(clk), .rst(rst || new_game), .left(left), .right(right), .cursor(cursor)
  );
  always_comb begin
    cur_col = '0;
    for (int c = 0; c < COLS; c++) if (cursor[c]) cur_col = CW'(c);
    all_full = 1'b1;
    for (int c = 0; c < COLS; c++) all_full &= (h_q[c] == HW'(ROWS));
    me    = player_q ? PL_B : PL_A;
    dr_s  = PRW'(DIR_DR[dir_q]);
    dc_s  = PCW'(DIR_DC[dir_q]);
    in_b  = int'(pr_q) >= 0 && int'(pr_q) < ROWS && int'(pc_q) >= 0 && int'(pc_q) < COLS;
    pcell = in_b ? board_q[bidx(int'(pr_q), int'(pc_q)) +: 2] : EMPTY;
    match = in_b && pcell == me;
    state_d = state_q; dir_d = dir_q; board_d = board_q; mask_d = mask_q; h_d = h_q;
    player_d = player_q; win_a_d = win_a_q; win_b_d = win_b_q; full_d = full_q;
    inv_d = 1'b0; side_d = side_q; col_d = col_q; cnt_d = cnt_q;
    lr_d = lr_q; lc_d = lc_q; pr_d = pr_q; pc_d = pc_q; ner_d = ner_q; nec_d = nec_q;
    case (state_q)
      S_IDLE: if (put_valid && put_ready) begin
        col_d   = cur_col;
        state_d = S_DROP;
      end
      S_DROP: if (h_q[col_q] == HW'(ROWS)) begin
        inv_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        board_d[bidx(int'(h_q[col_q]), int'(col_q)) +: 2] = me;
        h_d[col_q] = h_q[col_q] + HW'(1);
        lr_d    = $signed(PRW'(h_q[col_q]));
        lc_d    = $signed(PCW'(col_q));
        dir_d   = DIR_H;
        side_d  = 1'b0;
        cnt_d   = KW'(1);
        pr_d    = lr_d;
        pc_d    = lc_d + PCW'(1);
        ner_d   = lr_d;
        nec_d   = lc_d;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // ner/nec track the far end of the - side, where the highlight walk starts
        if (match) begin
          cnt_d = cnt_q + KW'(1);
          pr_d  = side_q ? pr_q - dr_s : pr_q + dr_s;
          pc_d  = side_q ? pc_q - dc_s : pc_q + dc_s;
          if (side_q) begin
            ner_d = pr_q;
            nec_d = pc_q;
          end
        end
        if (!match || cnt_d == KW'(WIN_LEN)) begin
          if (cnt_d == KW'(WIN_LEN)) begin
            state_d = S_HILITE;
            pr_d    = ner_d;
            pc_d    = nec_d;
          end else if (!side_q) begin
            side_d = 1'b1;
            pr_d   = lr_q - dr_s;
            pc_d   = lc_q - dc_s;
          end else if (dir_q == DIR_A) begin
            state_d = S_FINISH;
          end else begin
            dir_d  = dir_t'(dir_q + 2'd1);
            side_d = 1'b0;
            cnt_d  = KW'(1);
            pr_d   = lr_q + PRW'(DIR_DR[dir_d]);
            pc_d   = lc_q + PCW'(DIR_DC[dir_d]);
            ner_d  = lr_q;
            nec_d  = lc_q;
          end
        end
      end
      S_HILITE: begin
        mask_d[midx(int'(pr_q), int'(pc_q))] = 1'b1;
        pr_d    = pr_q + dr_s;
        pc_d    = pc_q + dc_s;
        cnt_d   = cnt_q - KW'(1);
        state_d = (cnt_q == KW'(1)) ? S_FINISH : S_HILITE;
      end
      S_FINISH: begin
        win_a_d  = win_a_q || (|mask_q && !player_q);
        win_b_d  = win_b_q || (|mask_q && player_q);
        full_d   = all_full && !(|mask_q);
        player_d = !player_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state_q <= S_IDLE; dir_q <= DIR_H; board_q <= '0; mask_q <= '0; h_q <= '{default: '0};
      player_q <= 1'b0; win_a_q <= 1'b0; win_b_q <= 1'b0; full_q <= 1'b0; inv_q <= 1'b0;
      side_q <= 1'b0; col_q <= '0; cnt_q <= '0;
      lr_q <= '0; lc_q <= '0; pr_q <= '0; pc_q <= '0; ner_q <= '0; nec_q <= '0;
    end else begin
      state_q <= state_d; dir_q <= dir_d; board_q <= board_d; mask_q <= mask_d; h_q <= h_d;
      player_q <= player_d; win_a_q <= win_a_d; win_b_q <= win_b_d; full_q <= full_d; inv_q <= inv_d;
      side_q <= side_d; col_q <= col_d; cnt_q <= cnt_d;
      lr_q <= lr_d; lc_q <= lc_d; pr_q <= pr_d; pc_q <= pc_d; ner_q <= ner_d; nec_q <= nec_d;
    end
  end
  assign put_ready    = state_q == S_IDLE && !win_a_q && !win_b_q && !full_q;
  assign player       = player_q;
  assign board        = board_q;
  assign win_mask     = mask_q;
  assign move_done    = state_q == S_FINISH;
  assign invalid_move = inv_q;
  assign win_a        = win_a_q;
  assign win_b        = win_b_q;
  assign full_panel   = full_q;
endmodule

// File: tb/tb_connect_n_core.sv
// tb_connect_n_core: connect-N core against a board-level reference model
module tb_connect_n_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, new_game, left, right, put_valid;
  logic put_ready, player, move_done, invalid_move, win_a, win_b, full_panel;
  logic [6:0] cursor;
  logic [83:0] board;
  logic [41:0] win_mask;
  logic new_game2, left2, right2, put_valid2;
  logic put_ready2, player2, move_done2, invalid_move2, win_a2, win_b2, full_panel2;
  logic [3:0] cursor2;
  logic [31:0] board2;
  logic [15:0] win_mask2;
  int checks = 0, failures = 0;
  int mb [6][7];
  int mh [7];
  int mpl, mcur, cur2;
  bit mwa, mwb, mfull;
  logic [41:0] mmask;

  connect_n_core dut (
    .clk(clk), .rst(rst), .new_game(new_game), .left(left), .right(right),
    .put_valid(put_valid), .put_ready(put_ready), .cursor(cursor), .player(player),
    .board(board), .win_mask(win_mask), .move_done(move_done), .invalid_move(invalid_move),
    .win_a(win_a), .win_b(win_b), .full_panel(full_panel)
  );
  connect_n_core #(.ROWS(4), .COLS(4), .WIN_LEN(3)) dut2 (
    .clk(clk), .rst(rst), .new_game(new_game2), .left(left2), .right(right2),
    .put_valid(put_valid2), .put_ready(put_ready2), .cursor(cursor2), .player(player2),
    .board(board2), .win_mask(win_mask2), .move_done(move_done2), .invalid_move(invalid_move2),
    .win_a(win_a2), .win_b(win_b2), .full_panel(full_panel2)
  );

  function automatic int mcell(int r, int c);
    if (r < 0 || r > 5 || c < 0 || c > 6) return 0;
    return mb[r][c];
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 6; r++) for (int c = 0; c < 7; c++) mb[r][c] = 0;
    for (int c = 0; c < 7; c++) mh[c] = 0;
    mpl = 0; mcur = 0; mwa = 0; mwb = 0; mfull = 0; mmask = '0;
  endfunction

  // Drop for the side to move; a run is counted + side first (capped at 3 extra), then - side.
  function automatic void model_drop(input int col, output bit inv);
    int r, p, pos, neg, dr, dc;
    bit won, full;
    int drs [4] = '{0, 1, 1, 1};
    int dcs [4] = '{1, 0, 1, -1};
    inv = (mh[col] == 6);
    if (inv) return;
    r = mh[col]; p = mpl + 1; mb[r][col] = p; mh[col]++; won = 0;
    for (int d = 0; d < 4 && !won; d++) begin
      dr = drs[d]; dc = dcs[d]; pos = 0; neg = 0;
      while (pos < 3 && mcell(r + (pos + 1) * dr, col + (pos + 1) * dc) == p) pos++;
      while (pos + neg < 3 && mcell(r - (neg + 1) * dr, col - (neg + 1) * dc) == p) neg++;
      if (pos + neg >= 3) begin
        won = 1;
        for (int k = -neg; k <= pos; k++) mmask[(r + k * dr) * 7 + col + k * dc] = 1'b1;
      end
    end
    if (won && mpl == 0) mwa = 1;
    if (won && mpl == 1) mwb = 1;
    full = 1;
    for (int c = 0; c < 7; c++) full &= (mh[c] == 6);
    mfull = full && !won;
    mpl = 1 - mpl;
  endfunction

  function automatic logic [83:0] mboard();
    logic [83:0] b = '0;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 7; c++) b[(r * 7 + c) * 2 +: 2] = 2'(mb[r][c]);
    return b;
  endfunction

  task automatic do_reset();
    rst = 1; new_game = 0; left = 0; right = 0; put_valid = 0;
    left2 = 0; right2 = 0; put_valid2 = 0; new_game2 = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    cur2 = 0;
  endtask

  task automatic put_main(input int col, output int lat, output bit done, output bit inv);
    while (mcur != col) begin
      right = 1; @(negedge clk); right = 0; mcur = (mcur + 1) % 7;
    end
    put_valid = 1; done = 0; inv = 0; lat = 0;
    for (int n = 1; n <= 60 && !done && !inv; n++) begin
      @(negedge clk);
      put_valid = 0;
      if (move_done) begin done = 1; lat = n; end
      if (invalid_move) begin inv = 1; lat = n; end
    end
    @(negedge clk);
  endtask

  task automatic put2(input int col, output bit done);
    while (cur2 != col) begin
      right2 = 1; @(negedge clk); right2 = 0; cur2 = (cur2 + 1) % 4;
    end
    put_valid2 = 1; done = 0;
    for (int n = 1; n <= 60 && !done; n++) begin
      @(negedge clk);
      put_valid2 = 0;
      if (move_done2) done = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (board !== '0) begin failures++; $display("FAIL reset_board got=%h exp=0", board); end
    checks++; if (win_mask !== '0) begin failures++; $display("FAIL reset_mask got=%h exp=0", win_mask); end
    checks++; if (cursor !== 7'b0000001) begin failures++; $display("FAIL reset_cursor got=%b exp=0000001", cursor); end
    checks++; if (player !== 1'b0 || put_ready !== 1'b1) begin failures++; $display("FAIL reset_turn got player=%b ready=%b exp 0,1", player, put_ready); end
    checks++; if ({move_done, invalid_move, win_a, win_b, full_panel} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {move_done, invalid_move, win_a, win_b, full_panel}); end
    checks++; if (board2 !== '0 || cursor2 !== 4'b0001) begin failures++; $display("FAIL reset_dut2 got board=%h cursor=%b", board2, cursor2); end
  endtask

  task automatic test_single_drop();
    int lat; bit done, inv, minv;
    do_reset();
    put_main(0, lat, done, inv);
    model_drop(0, minv);
    checks++; if (!done || lat != 10) begin failures++; $display("FAIL single_latency got done=%b lat=%0d exp done=1 lat=10", done, lat); end
    checks++; if (inv !== 1'b0) begin failures++; $display("FAIL single_invalid got=%b exp=0", inv); end
    checks++; if (board[1:0] !== 2'b01 || board !== mboard()) begin failures++; $display("FAIL single_board got=%h exp=%h", board, mboard()); end
    checks++; if (player !== 1'b1) begin failures++; $display("FAIL single_player got=%b exp=1", player); end
  endtask

  task automatic test_cursor();
    int l, r;
    do_reset();
    left = 1; @(negedge clk); left = 0;
    checks++; if (cursor !== 7'b1000000) begin failures++; $display("FAIL cursor_left_wrap got=%b exp=1000000", cursor); end
    right = 1; @(negedge clk); right = 0;
    checks++; if (cursor !== 7'b0000001) begin failures++; $display("FAIL cursor_right_wrap got=%b exp=0000001", cursor); end
    left = 1; right = 1; @(negedge clk); left = 0; right = 0;
    checks++; if (cursor !== 7'b0000001) begin failures++; $display("FAIL cursor_both got=%b exp=0000001", cursor); end
    mcur = 0;
    for (int i = 0; i < 20; i++) begin
      l = $urandom_range(0, 1); r = $urandom_range(0, 1);
      left = l[0]; right = r[0]; @(negedge clk); left = 0; right = 0;
      if (l == 1 && r == 0) mcur = (mcur + 6) % 7;
      if (r == 1 && l == 0) mcur = (mcur + 1) % 7;
      checks++; if (cursor !== 7'(1 << mcur)) begin failures++; $display("FAIL cursor_random got=%b exp=%b", cursor, 7'(1 << mcur)); end
    end
  endtask

  task automatic test_full_column();
    int lat, bad; bit done, inv, minv, seen;
    do_reset();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      put_main(3, lat, done, inv); model_drop(3, minv);
      if (!done || inv) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL fillcol_moves got bad=%0d exp=0", bad); end
    put_main(3, lat, done, inv); model_drop(3, minv);
    checks++; if (!inv || lat != 2) begin failures++; $display("FAIL fillcol_invalid got inv=%b lat=%0d exp inv=1 lat=2", inv, lat); end
    seen = done;
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= move_done; end
    checks++; if (seen) begin failures++; $display("FAIL fillcol_no_done got move_done=1 exp=0"); end
    checks++; if (player !== 1'b0 || board !== mboard()) begin failures++; $display("FAIL fillcol_state got player=%b board=%h exp 0,%h", player, board, mboard()); end
  endtask

  task automatic test_row_win();
    int seq [7] = '{0, 6, 1, 6, 2, 6, 3};
    int lat; bit done, inv, minv, seen;
    logic [83:0] snap;
    do_reset();
    foreach (seq[i]) begin put_main(seq[i], lat, done, inv); model_drop(seq[i], minv); end
    checks++; if (win_a !== 1'b1 || win_b !== 1'b0) begin failures++; $display("FAIL rowwin_flags got a=%b b=%b exp 1,0", win_a, win_b); end
    checks++; if (win_mask !== 42'hF || win_mask !== mmask) begin failures++; $display("FAIL rowwin_mask got=%h exp=%h", win_mask, mmask); end
    checks++; if (put_ready !== 1'b0) begin failures++; $display("FAIL rowwin_ready got=%b exp=0", put_ready); end
    snap = board; seen = 0;
    put_valid = 1;
    for (int i = 0; i < 15; i++) begin @(negedge clk); seen |= move_done | invalid_move; end
    put_valid = 0;
    checks++; if (seen || board !== snap) begin failures++; $display("FAIL rowwin_ignore got activity=%b board=%h exp 0,%h", seen, board, snap); end
  endtask

  task automatic test_antidiag();
    int seq [7] = '{2, 1, 1, 0, 3, 0, 0};
    int bad; bit done;
    do_reset();
    bad = 0;
    foreach (seq[i]) begin put2(seq[i], done); if (!done) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL antidiag_moves got bad=%0d exp=0", bad); end
    checks++; if (win_a2 !== 1'b1 || win_b2 !== 1'b0) begin failures++; $display("FAIL antidiag_flags got a=%b b=%b exp 1,0", win_a2, win_b2); end
    checks++; if (win_mask2 !== 16'h0124) begin failures++; $display("FAIL antidiag_mask got=%h exp=0124", win_mask2); end
    checks++; if (put_ready2 !== 1'b0) begin failures++; $display("FAIL antidiag_ready got=%b exp=0", put_ready2); end
  endtask

  task automatic test_draw();
    int px [3] = '{0, 1, 4};
    int py [3] = '{2, 3, 6};
    int seq[$];
    int lat, bad; bit done, inv, minv;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      seq.push_back(px[p]);
      repeat (6) seq.push_back(py[p]);
      repeat (5) seq.push_back(px[p]);
    end
    repeat (6) seq.push_back(5);
    bad = 0;
    foreach (seq[i]) begin
      put_main(seq[i], lat, done, inv); model_drop(seq[i], minv);
      if (!done || inv || board !== mboard() || player !== mpl[0]) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL draw_moves got bad=%0d exp=0", bad); end
    checks++; if (full_panel !== 1'b1 || win_a !== 1'b0 || win_b !== 1'b0) begin
      failures++; $display("FAIL draw_flags got full=%b a=%b b=%b exp 1,0,0", full_panel, win_a, win_b); end
    checks++; if (put_ready !== 1'b0 || win_mask !== '0) begin failures++; $display("FAIL draw_ready got ready=%b mask=%h exp 0,0", put_ready, win_mask); end
  endtask

  task automatic test_new_game_abort();
    bit seen;
    do_reset();
    while (mcur != 3) begin right = 1; @(negedge clk); right = 0; mcur++; end
    put_valid = 1; @(negedge clk); put_valid = 0;
    repeat (2) @(negedge clk);
    new_game = 1; @(negedge clk); new_game = 0;
    checks++; if (board !== '0 || win_mask !== '0) begin failures++; $display("FAIL abort_board got board=%h mask=%h exp 0,0", board, win_mask); end
    checks++; if (cursor !== 7'b0000001 || player !== 1'b0 || put_ready !== 1'b1) begin
      failures++; $display("FAIL abort_state got cursor=%b player=%b ready=%b exp 0000001,0,1", cursor, player, put_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= move_done | invalid_move | win_a | win_b | full_panel; end
    checks++; if (seen) begin failures++; $display("FAIL abort_quiet got flag activity=1 exp=0"); end
    model_reset();
  endtask

  task automatic test_random_games();
    int lat, col; bit done, inv, minv;
    for (int g = 0; g < 5; g++) begin
      do_reset();
      for (int m = 0; m < 45 && !(mwa || mwb || mfull); m++) begin
        col = $urandom_range(0, 6);
        put_main(col, lat, done, inv);
        model_drop(col, minv);
        checks++; if (inv !== minv || (minv ? lat != 2 : (!done || lat > 35))) begin
          failures++; $display("FAIL rand_outcome col=%0d got inv=%b done=%b lat=%0d exp inv=%b", col, inv, done, lat, minv); end
        checks++; if (board !== mboard() || win_mask !== mmask) begin
          failures++; $display("FAIL rand_board got board=%h mask=%h exp %h %h", board, win_mask, mboard(), mmask); end
        checks++; if ({player, win_a, win_b, full_panel, put_ready} !== {mpl[0], mwa, mwb, mfull, !(mwa || mwb || mfull)}) begin
          failures++; $display("FAIL rand_flags got=%b exp=%b", {player, win_a, win_b, full_panel, put_ready},
                               {mpl[0], mwa, mwb, mfull, !(mwa || mwb || mfull)}); end
      end
    end
  endtask

  initial begin
    rst = 1; new_game = 0; left = 0; right = 0; put_valid = 0;
    new_game2 = 0; left2 = 0; right2 = 0; put_valid2 = 0;
    model_reset();
    test_reset();
    test_single_drop();
    test_cursor();
    test_full_column();
    test_row_win();
    test_antidiag();
    test_draw();
    test_new_game_abort();
    test_random_games();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
